shift_rows_pipe: RTL and testbench
==================================

# shift_rows_pipe

Parametrised, registered Rijndael ShiftRows/InvShiftRows stage with a valid/ready handshake. It generalises the fixed 128-bit combinational row shifter to Rijndael block widths Nb = 4, 6 or 8 columns and adds a per-transfer inverse mode, so the encrypt and decrypt round datapaths share one instance. It sits between SubBytes and MixColumns in the iterative AES/Rijndael round core and provides full-throughput back-pressure isolation through a 2-entry skid buffer.

## Interface
- NB, default 4: column count; legal values are 4, 6 and 8. Any other value fails elaboration.
- TAG_W, default 4: width of the sideband tag carried alongside each state (round number or stream id).
- W, derived as 32*NB: state width in bits.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream state present.
- in_ready  out  1  stage can accept a state; driven directly from a register.
- in_data  in  W  state, column-major; byte (row r, col c) is at bits [W-1-8*(4c+r) -: 8].
- in_inv  in  1  1 selects InvShiftRows, 0 selects ShiftRows.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  W  shifted state, same byte layout as in_data.
- out_tag  out  TAG_W  tag of the state on out_data.

## Operation
- Row offsets: for NB=4 and NB=6 the offsets are {0,1,2,3}; for NB=8 they are {0,1,3,4}.
- Forward mode: out[r][c] = in[r][(c+off_r) mod NB].
- Inverse mode: out[r][c] = in[r][(c−off_r+NB) mod NB].
- The mode is sampled per transfer and travels with its data. Mixed modes back to back are legal.
- The shift is combinational on in_data. The result is registered on the input handshake (in_valid && in_ready).
- Storage consists of a primary register (drives out_*) and a skid register.
- State machine with three states:
  - EMPTY: out_valid=0, in_ready=1. On an input handshake, go to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input handshake and output handshake in the same cycle: load primary, stay in ONE.
    - Input handshake only (out_ready=0): load skid, go to FULL.
    - Output handshake only: go to EMPTY.
  - FULL: out_valid=1, in_ready=0. On an output handshake, move skid to primary and go to ONE.
- Order is strictly FIFO, with no drop and no duplication.
- out_data and out_tag are stable while out_valid=1 and out_ready=0.
- Reset (synchronous, including mid-transfer):
  - The state goes to EMPTY.
  - out_valid=0 and in_ready=1 on the cycle after rst is sampled high.
  - out_data and out_tag are cleared to 0.
  - Skid contents are discarded. In-flight states are lost; upstream must reissue them.
- While rst=1, no input handshake is accepted: in_ready is forced 0 during reset.

## Timing
- Latency is 1 cycle: data accepted on edge N appears on out_data after edge N, with out_valid=1 in cycle N+1.
- Throughput is one state per cycle while out_ready=1.
- in_ready reacts one cycle after downstream stalls; the skid entry absorbs the transfer in flight.
- No combinational path exists from out_ready to in_ready, or from in_* to out_*.

## Configuration
- SHIFT_ROWS_INV_EN defined: in_inv is honoured and both shift networks are built.
- SHIFT_ROWS_INV_EN undefined (encrypt-only core):
  - in_inv is ignored and the inverse network is not synthesised.
  - Forward shift is applied to every state, whatever the value of in_inv.
  - Port list is unchanged.

## Structure
- Shared package aes_pkg holds:
  - typedef for a byte and for a column;
  - localparam offset tables OFF_NB4, OFF_NB6, OFF_NB8;
  - function row_offset(nb, r).
- Sub-module row_rotate (parameters NB and OFF; inputs row and inv; output rotated row) implements one row. It is instantiated four times under generate, one per row.
- Skid/handshake control lives in shift_rows_pipe itself.

## Test plan
- NB=4 forward, single transfer: in d42711aee0bf98f1b8b45de51e415230 → out d4bf5d30e0b452aeb84111f11e2798e5 one cycle later, tag preserved.
- NB=4 inverse: in d4bf5d30e0b452aeb84111f11e2798e5 with in_inv=1 → out d42711aee0bf98f1b8b45de51e415230. Without SHIFT_ROWS_INV_EN, the same stimulus → forward result.
- NB=8 forward, bytes 00..1f in index order → out column 0 = 00050e13, column 7 = 1c010a0f.
- Back-pressure: 8-state burst with out_ready toggling 1,0,0,1,… →
  - in_ready drops only after the skid entry fills;
  - all 8 states appear in order with no loss;
  - out_data is stable during stalls.
- Alternating in_inv per cycle at full rate → each output matches its own mode; throughput is 1 state per cycle.
- rst asserted while in FULL → next cycle out_valid=0, in_ready=1, out_data=0; the next accepted state emerges normally.

Source files
------------

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared Rijndael types, ShiftRows offset tables and lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] col_t;

    // Nibble r holds the left-rotation applied to row r.
    localparam logic [15:0] OFF_NB4 = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [15:0] OFF_NB6 = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [15:0] OFF_NB8 = {4'd4, 4'd3, 4'd1, 4'd0};

    function automatic int row_offset(input int nb, input int r);
        logic [15:0] tbl;
        case (nb)
            8:       tbl = OFF_NB8;
            6:       tbl = OFF_NB6;
            default: tbl = OFF_NB4;
        endcase
        return int'(tbl[4*r +: 4]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rows_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_pipe_if
// Description : Valid/ready state channel (in and out sides) of shift_rows_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_rows_pipe_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    localparam int W = 32 * NB;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/row_rotate.sv
`default_nettype none
// ============================================================================
// Module      : row_rotate
// Description : Rotates one state row left (forward) or right (inverse) by OFF
//               bytes. Inverse network only built with SHIFT_ROWS_INV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module row_rotate #(
    parameter int NB  = 4,
    parameter int OFF = 0
) (
    input  wire logic [8*NB-1:0] row,
    input  wire logic            inv,
    output logic      [8*NB-1:0] rotated
);

    logic [8*NB-1:0] w_fwd;

    // Byte c sits at the MSB end for c=0, matching the column-major state layout.
    for (genvar c = 0; c < NB; c++) begin : g_fwd
        localparam int c_src = (c + OFF) % NB;
        assign w_fwd[8*NB-1-8*c -: 8] = row[8*NB-1-8*c_src -: 8];
    end

`ifdef SHIFT_ROWS_INV_EN
    logic [8*NB-1:0] w_inv;

    for (genvar c = 0; c < NB; c++) begin : g_inv
        localparam int c_src = (c - OFF + NB) % NB;
        assign w_inv[8*NB-1-8*c -: 8] = row[8*NB-1-8*c_src -: 8];
    end

    assign rotated = inv ? w_inv : w_fwd;
`else
    logic w_unused_inv;
    assign w_unused_inv = inv;
    assign rotated      = w_fwd;
`endif

endmodule
`default_nettype wire

// File: rtl/shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_pipe
// Description : Registered ShiftRows/InvShiftRows stage for Nb = 4/6/8 with a
//               2-entry skid buffer. InvShiftRows honoured with SHIFT_ROWS_INV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_rows_pipe_if.slave bus
);

    localparam int W = 32 * NB;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0]     w_shifted;
    logic             w_in_hs;
    logic             w_out_hs;

    state_t           r_state;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [W-1:0]     r_prim_data;
    logic [TAG_W-1:0] r_prim_tag;
    logic [W-1:0]     r_skid_data;
    logic [TAG_W-1:0] r_skid_tag;

    // Gather each row out of the column-major state, rotate it, scatter it back.
    for (genvar r = 0; r < 4; r++) begin : g_row
        logic [8*NB-1:0] w_row_in;
        logic [8*NB-1:0] w_row_out;

        for (genvar c = 0; c < NB; c++) begin : g_byte
            assign w_row_in[8*NB-1-8*c -: 8]      = bus.in_data[W-1-8*(4*c+r) -: 8];
            assign w_shifted[W-1-8*(4*c+r) -: 8] = w_row_out[8*NB-1-8*c -: 8];
        end

        row_rotate #(
            .NB  (NB),
            .OFF (row_offset(NB, r))
        ) u_row_rotate (
            .row     (w_row_in),
            .inv     (bus.in_inv),
            .rotated (w_row_out)
        );
    end

    assign bus.in_ready  = r_in_ready & ~rst;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_prim_data;
    assign bus.out_tag   = r_prim_tag;

    assign w_in_hs  = bus.in_valid & bus.in_ready;
    assign w_out_hs = r_out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_prim_data <= '0;
            r_prim_tag  <= '0;
            r_skid_data <= '0;
            r_skid_tag  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_hs) begin
                        r_prim_data <= w_shifted;
                        r_prim_tag  <= bus.in_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_hs && w_out_hs) begin
                        r_prim_data <= w_shifted;
                        r_prim_tag  <= bus.in_tag;
                    end else if (w_in_hs) begin
                        // Downstream stalled: park the in-flight transfer.
                        r_skid_data <= w_shifted;
                        r_skid_tag  <= bus.in_tag;
                        r_in_ready  <= 1'b0;
                        r_state     <= S_FULL;
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_hs) begin
                        r_prim_data <= r_skid_data;
                        r_prim_tag  <= r_skid_tag;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows_pipe
// Description : Randomised scoreboard bench for shift_rows_pipe (NB=4 and NB=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_rows_pipe;

    localparam int TAG_W = 4;
    localparam logic [127:0] D_A = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] D_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] D_C = 128'hd4b411e5e0419830b8275dae1ebf52f1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_rows_pipe_if #(.NB(4), .TAG_W(TAG_W)) bus4 ();
    shift_rows_pipe_if #(.NB(8), .TAG_W(TAG_W)) bus8 ();

    shift_rows_pipe #(.NB(4), .TAG_W(TAG_W)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    shift_rows_pipe #(.NB(8), .TAG_W(TAG_W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;
    int          ready_mode  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_off(input int nb, input int r);
        if (nb == 8 && r >= 2) return r + 1;
        return r;
    endfunction

    function automatic logic [255:0] model_shift(input logic [255:0] d, input bit inv, input int nb);
        int           w;
        int           src;
        logic [7:0]   b [32];
        logic [255:0] o;
        w = 32 * nb;
        o = '0;
        for (int k = 0; k < 4 * nb; k++) b[k] = d[w-1-8*k -: 8];
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (inv) src = (c - model_off(nb, r) + nb) % nb;
                else     src = (c + model_off(nb, r)) % nb;
                o[w-1-8*(4*c+r) -: 8] = b[4*src + r];
            end
        end
        return o;
    endfunction

    function automatic bit eff_inv(input bit inv);
`ifdef SHIFT_ROWS_INV_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct packed {
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb [$];
    exp_t             e;
    exp_t             n;
    bit               prev_stall = 1'b0;
    bit               post_rst   = 1'b0;
    logic [127:0]     prev_data;
    logic [TAG_W-1:0] prev_tag;

    // Compare process: occupancy, ordering, stall stability and reset values.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
                post_rst   = 1'b1;
                check("in_ready_during_rst", bus4.in_ready, 0);
            end else begin
                if (post_rst) begin
                    check("rst_out_valid", bus4.out_valid, 0);
                    check("rst_out_data", bus4.out_data, 0);
                    check("rst_out_tag", bus4.out_tag, 0);
                    post_rst = 1'b0;
                end
                check("in_ready_occupancy", bus4.in_ready, sb.size() < 2);
                check("out_valid_occupancy", bus4.out_valid, sb.size() != 0);
                if (prev_stall) begin
                    check("stall_data_stable", bus4.out_data, prev_data);
                    check("stall_tag_stable", bus4.out_tag, prev_tag);
                end
                if (bus4.out_valid && bus4.out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_output: got %h expected nothing", bus4.out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data_order", bus4.out_data, e.data);
                        check("out_tag_order", bus4.out_tag, e.tag);
                    end
                end
                if (bus4.in_valid && bus4.in_ready) begin
                    n.data = model_shift(bus4.in_data, eff_inv(bus4.in_inv), 4)[127:0];
                    n.tag  = bus4.in_tag;
                    sb.push_back(n);
                end
                prev_stall = bus4.out_valid && !bus4.out_ready;
                prev_data  = bus4.out_data;
                prev_tag   = bus4.out_tag;
            end
        end
    end

    initial begin
        bus4.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus4.out_ready = 1'b1;
                1:       bus4.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       bus4.out_ready = 1'($urandom_range(0, 1));
                default: bus4.out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [127:0] d, input bit inv, input logic [TAG_W-1:0] tag);
        bit acc;
        acc           = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = d;
        bus4.in_inv   = inv;
        bus4.in_tag   = tag;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = bus4.in_ready;
            tick();
        end
        bus4.in_valid = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got in_ready=0 for 64 cycles expected acceptance");
        end
    endtask

    task automatic expect_out4(input string name, input logic [127:0] d, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        check({name, "_valid"}, bus4.out_valid, 1);
        check({name, "_data"}, bus4.out_data, d);
        check({name, "_tag"}, bus4.out_tag, tag);
        tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !bus4.out_valid) break;
            tick();
        end
        check("drain_empty", sb.size(), 0);
    endtask

    logic [255:0] d8;
    logic [255:0] m8;
    int unsigned  t0;

    initial begin
        rst            = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_inv    = 1'b0;
        bus4.in_tag    = '0;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus8.in_inv    = 1'b0;
        bus8.in_tag    = '0;
        bus8.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Hand-computed values that pin the reference model.
        check("model_fwd_nb4", model_shift(D_A, 1'b0, 4), D_B);
        check("model_inv_nb4", model_shift(D_B, 1'b1, 4), D_A);
        check("model_fwd_twice_nb4", model_shift(D_B, 1'b0, 4), D_C);
        for (int k = 0; k < 32; k++) d8[255-8*k -: 8] = 8'(k);
        m8 = model_shift(d8, 1'b0, 8);
        check("model_nb8_col0", m8[255 -: 32], 32'h00050e13);
        check("model_nb8_col7", m8[31:0], 32'h1c010a0f);
        tick();

        // Directed single transfers, one-cycle latency.
        send4(D_A, 1'b0, 4'h5);
        expect_out4("fwd_single", D_B, 4'h5);
        send4(D_B, 1'b1, 4'ha);
`ifdef SHIFT_ROWS_INV_EN
        expect_out4("inv_single", D_A, 4'ha);
`else
        expect_out4("inv_ignored", D_C, 4'ha);
`endif

        // NB=8 instance, bytes 00..1f.
        bus8.in_valid = 1'b1;
        bus8.in_data  = d8;
        bus8.in_tag   = 4'h3;
        @(negedge clk);
        check("nb8_in_ready", bus8.in_ready, 1);
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        check("nb8_out_valid", bus8.out_valid, 1);
        check("nb8_col0", bus8.out_data[255 -: 32], 32'h00050e13);
        check("nb8_col7", bus8.out_data[31:0], 32'h1c010a0f);
        check("nb8_full", bus8.out_data, model_shift(d8, 1'b0, 8));
        check("nb8_tag", bus8.out_tag, 4'h3);
        tick();

        // Back-pressure burst with out_ready 1,0,0,1,...
        ready_mode = 1;
        for (int i = 0; i < 8; i++) send4(rand128(), 1'($urandom_range(0, 1)), 4'(i));
        ready_mode = 0;
        drain();

        // Alternating modes back to back at full rate.
        t0 = cyc;
        for (int i = 0; i < 16; i++) send4(rand128(), 1'(i & 1), 4'(i));
        check("full_rate_cycles", cyc - t0, 16);
        drain();

        // Reset while FULL.
        ready_mode = 3;
        tick();
        send4(rand128(), 1'b0, 4'h1);
        send4(rand128(), 1'b1, 4'h2);
        @(negedge clk);
        check("full_in_ready_low", bus4.in_ready, 0);
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        ready_mode = 0;
        send4(D_A, 1'b0, 4'h7);
        expect_out4("after_rst", D_B, 4'h7);
        drain();

        // Random traffic with random back-pressure.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send4(rand128(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        ready_mode = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
